dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port 128x32 data memory between two requesters: port A (CPU load/store stage) and port B (debug/DMA loader).
- Issues at most one memory access per cycle and arbitrates round-robin.
- Supports a lock so a requester can hold exclusive access for read-modify-write sequences.
- Routes the 1-cycle-latency registered read data back to the requester that issued the read.

Parameters:
- AW, 7, memory address width
- DW, 32, data width
- LOCK_TIMEOUT, 16, idle cycles after which an unused lock is forcibly released (must be >= 1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- a_req  in  1  A requests an access this cycle
- a_we  in  1  1=write, 0=read
- a_lock  in  1  keep exclusive ownership after this access
- a_addr  in  AW  word address
- a_wdata  in  DW  write data
- a_gnt  out  1  access accepted this cycle (combinational)
- a_rvalid  out  1  read data valid for A
- a_rdata  out  DW  read data for A
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for port B
- lock_err  out  1  one-cycle pulse when a lock times out
- dm_addr  out  AW  to memory addr
- dm_rd  out  1  to memory rd
- dm_wr  out  1  to memory wr
- dm_wdata  out  DW  to memory wdata
- dm_rdata  in  DW  from memory rdata; valid the cycle after dm_rd is sampled

Behaviour:
- State: last_grant (A/B), lock_owner (NONE/A/B), lock_idle counter (clog2(LOCK_TIMEOUT+1) bits), rv_a, rv_b.
- Reset values: last_grant=B, so A wins first; lock_owner=NONE; counter=0; rv_a=rv_b=0; lock_err=0.
- While rst=1: a_gnt=b_gnt=0 and dm_rd=dm_wr=0.

Grant (combinational, each cycle):
- lock_owner=NONE:
  - Only one requester asserts req: grant it.
  - Both assert req: grant the one that is not last_grant.
- lock_owner=X: only X may be granted. The other requester stalls with gnt=0 and must hold its req and fields stable.

Memory drive:
- On a grant: dm_addr/dm_wdata come from the winner; dm_wr=winner_we; dm_rd=~winner_we.
- With no grant: dm_rd=dm_wr=0; dm_addr and dm_wdata are don't-care but held at A's values.

Read return:
- A read granted in cycle N sets rv_X at the N edge.
- X_rvalid=rv_X in cycle N+1.
- X_rdata=dm_rdata, passed through unregistered, for both ports. Consumers qualify with rvalid.
- Back-to-back reads, including alternating A/B, return in order, one per cycle.
- Writes never raise rvalid.

Lock:
- On a grant to X: last_grant<=X.
- Granted with lock=1: lock_owner<=X and counter cleared.
- Granted with lock=0 while the owner is X: lock_owner<=NONE.
- Lock held and owner not requesting: counter increments.
- Counter reaches LOCK_TIMEOUT: lock_owner<=NONE, counter<=0, lock_err pulses for 1 cycle. The other requester may be granted the following cycle.
- A lock=1 grant to a non-owner is impossible, because non-owners are never granted.

Other rules:
- Same-address write followed by read in the next cycle returns the new data. This follows from memory ordering; no bypass logic.
- Reset asserted mid-lock or with a read in flight: the lock is dropped and the pending rvalid is suppressed (rv_X cleared at the rst edge).

Optional Feature:
DM_ARB_STATS_EN:
- Defined: adds outputs a_gnt_cnt[15:0], b_gnt_cnt[15:0] and stall_cnt[15:0], all saturating at 16'hFFFF and cleared by rst.
  - a_gnt_cnt / b_gnt_cnt increment on each grant to that port.
  - stall_cnt increments on every cycle in which some req=1 but its gnt=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then A read addr 5 (mem[5]=32'hDEADBEEF): a_gnt same cycle, a_rvalid=1 with a_rdata=32'hDEADBEEF next cycle, b_rvalid=0.
- A and B both request reads for 4 cycles, no lock: grants go A,B,A,B; rvalids follow one cycle later on the matching port.
- B write addr 3 = 32'h12345678, then A read addr 3 the next cycle: a_rdata=32'h12345678.
- A read with a_lock=1, then B requesting for 3 cycles while A writes with lock=0 on the 3rd cycle: b_gnt=0 for those 3 cycles, b_gnt=1 on the 4th.
- A takes the lock then goes idle, B requesting, LOCK_TIMEOUT=16: lock_err pulses after 16 idle cycles and b_gnt=1 the next cycle.
- rst asserted the cycle after an A read grant: a_rvalid stays 0, all grants 0 during rst, and A wins first after release.

Source files
------------

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port 128x32 data memory
//             between port A (CPU load/store) and port B (debug/DMA loader).
//             One access per cycle. A requester can lock the memory for
//             read-modify-write sequences. An idle lock is released after
//             LOCK_TIMEOUT cycles and lock_err pulses. Read data returns one
//             cycle after the grant, on the port that issued the read.
//  Options  : define DM_ARB_STATS_EN to add saturating grant and stall
//             counters (a_gnt_cnt, b_gnt_cnt, stall_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
   parameter int AW           = 7,
   parameter int DW           = 32,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic          a_lock,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic          b_lock,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          lock_err,
`ifdef DM_ARB_STATS_EN
   output logic [15:0]   a_gnt_cnt,
   output logic [15:0]   b_gnt_cnt,
   output logic [15:0]   stall_cnt,
`endif
   output logic [AW-1:0] dm_addr,
   output logic          dm_rd,
   output logic          dm_wr,
   output logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] dm_rdata
);

   localparam int CW = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic {
      LG_A = 1'b0,
      LG_B = 1'b1
   } grant_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_t;

   grant_t        last_grant;
   owner_t        lock_owner;
   logic [CW-1:0] lock_idle;
   logic          rv_a;
   logic          rv_b;

   logic          grant_a;
   logic          grant_b;
   logic          win_lock;
   logic          timeout;

   // Pick this cycle's winner: the lock owner only, else round-robin.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst) begin
         case (lock_owner)
            OWN_NONE: begin
               if (a_req && b_req) begin
                  if (last_grant == LG_B) grant_a = 1'b1;
                  else                    grant_b = 1'b1;
               end else begin
                  grant_a = a_req;
                  grant_b = b_req;
               end
            end
            OWN_A:   grant_a = a_req;
            OWN_B:   grant_b = b_req;
            default: ;
         endcase
      end
   end

   assign win_lock = grant_b ? b_lock : a_lock;
   // Idle counter sitting at the limit means the owner has stayed away too long.
   assign timeout  = (lock_owner != OWN_NONE) && (lock_idle == CW'(LOCK_TIMEOUT));

   // Round-robin history, lock ownership, idle timer and read-return flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= LG_B;
         lock_owner <= OWN_NONE;
         lock_idle  <= '0;
         rv_a       <= 1'b0;
         rv_b       <= 1'b0;
      end else begin
         rv_a <= grant_a && !a_we;
         rv_b <= grant_b && !b_we;
         if (grant_a || grant_b) begin
            last_grant <= grant_b ? LG_B : LG_A;
            if (win_lock) begin
               lock_owner <= grant_b ? OWN_B : OWN_A;
               lock_idle  <= '0;
            end else if (lock_owner != OWN_NONE) begin
               // Only the owner can be granted while locked, so this is its unlock.
               lock_owner <= OWN_NONE;
               lock_idle  <= '0;
            end
         end else if (timeout) begin
            lock_owner <= OWN_NONE;
            lock_idle  <= '0;
         end else if (lock_owner != OWN_NONE) begin
            lock_idle <= lock_idle + CW'(1);
         end
      end
   end

   assign a_gnt    = grant_a;
   assign b_gnt    = grant_b;
   assign lock_err = timeout && !rst;

   // Suppress a read return that would otherwise appear during reset.
   assign a_rvalid = rv_a && !rst;
   assign b_rvalid = rv_b && !rst;
   assign a_rdata  = dm_rdata;
   assign b_rdata  = dm_rdata;

   assign dm_addr  = grant_b ? b_addr  : a_addr;
   assign dm_wdata = grant_b ? b_wdata : a_wdata;
   assign dm_wr    = (grant_a && a_we)  || (grant_b && b_we);
   assign dm_rd    = (grant_a && !a_we) || (grant_b && !b_we);

`ifdef DM_ARB_STATS_EN
   logic stall;
   assign stall = (a_req && !grant_a) || (b_req && !grant_b);

   // Saturating grant and stall statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_gnt_cnt <= '0;
         b_gnt_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (grant_a && (a_gnt_cnt != 16'hFFFF)) a_gnt_cnt <= a_gnt_cnt + 16'd1;
         if (grant_b && (b_gnt_cnt != 16'hFFFF)) b_gnt_cnt <= b_gnt_cnt + 16'd1;
         if (stall   && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_arbiter
//  Purpose  : Directed self-checking bench for dm_arbiter with a behavioural
//             1-cycle-latency memory and a read-return scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

   logic        clk;
   logic        rst;
   logic        a_req, a_we, a_lock;
   logic [6:0]  a_addr;
   logic [31:0] a_wdata;
   logic        a_gnt, a_rvalid;
   logic [31:0] a_rdata;
   logic        b_req, b_we, b_lock;
   logic [6:0]  b_addr;
   logic [31:0] b_wdata;
   logic        b_gnt, b_rvalid;
   logic [31:0] b_rdata;
   logic        lock_err;
   logic [6:0]  dm_addr;
   logic        dm_rd, dm_wr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
`ifdef DM_ARB_STATS_EN
   logic [15:0] a_gnt_cnt, b_gnt_cnt, stall_cnt;
`endif

   dm_arbiter #(.AW(7), .DW(32), .LOCK_TIMEOUT(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_req    (a_req),
      .a_we     (a_we),
      .a_lock   (a_lock),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_gnt    (a_gnt),
      .a_rvalid (a_rvalid),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_lock   (b_lock),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_gnt    (b_gnt),
      .b_rvalid (b_rvalid),
      .b_rdata  (b_rdata),
      .lock_err (lock_err),
`ifdef DM_ARB_STATS_EN
      .a_gnt_cnt(a_gnt_cnt),
      .b_gnt_cnt(b_gnt_cnt),
      .stall_cnt(stall_cnt),
`endif
      .dm_addr  (dm_addr),
      .dm_rd    (dm_rd),
      .dm_wr    (dm_wr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Power-on content of the memory model.
   function automatic logic [31:0] init_val(input logic [6:0] addr);
      if (addr == 7'd5) return 32'hDEADBEEF;
      return 32'hA000_0000 + {25'd0, addr};
   endfunction

   // Behavioural single-port memory with registered read data.
   bit [31:0] mem     [128];
   bit        written [128];
   always @(posedge clk) begin
      if (dm_wr) begin
         mem[dm_addr]     <= dm_wdata;
         written[dm_addr] <= 1'b1;
      end
      if (dm_rd) dm_rdata <= written[dm_addr] ? mem[dm_addr] : init_val(dm_addr);
   end

   typedef struct {
      bit          port;   // 0 = A, 1 = B
      logic [31:0] data;
   } rd_exp_t;

   rd_exp_t     sb[$];
   logic [31:0] shadow [128];
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, check once settled, then
   // record the read the bench expects to come back next cycle.
   task automatic step(input bit r,
                       input bit ar, input bit aw, input bit al,
                       input logic [6:0] aa, input logic [31:0] ad,
                       input bit br, input bit bw, input bit bl,
                       input logic [6:0] ba, input logic [31:0] bd,
                       input bit ega, input bit egb, input bit elerr);
      rd_exp_t e;
      bit      exp_rva;
      bit      exp_rvb;
      @(negedge clk);
      rst = r;
      a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
      #1;
      if (r) sb.delete();
      exp_rva = 1'b0;
      exp_rvb = 1'b0;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.port) begin
            exp_rvb = 1'b1;
            chk("b_rdata", b_rdata, e.data);
         end else begin
            exp_rva = 1'b1;
            chk("a_rdata", a_rdata, e.data);
         end
      end
      chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, exp_rva});
      chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, exp_rvb});
      chk("a_gnt",    {31'd0, a_gnt},    {31'd0, ega});
      chk("b_gnt",    {31'd0, b_gnt},    {31'd0, egb});
      chk("dm_rd",    {31'd0, dm_rd},    {31'd0, (ega && !aw) || (egb && !bw)});
      chk("dm_wr",    {31'd0, dm_wr},    {31'd0, (ega && aw) || (egb && bw)});
      chk("lock_err", {31'd0, lock_err}, {31'd0, elerr});
      if (ega) begin
         if (aw) shadow[aa] = ad;
         else    sb.push_back('{port: 1'b0, data: shadow[aa]});
      end
      if (egb) begin
         if (bw) shadow[ba] = bd;
         else    sb.push_back('{port: 1'b1, data: shadow[ba]});
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) shadow[i] = init_val(7'(i));
      rst = 1'b1;
      a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;

      // Reset with both requesting: no grants, no memory access.
      step(1, 1,0,0,7'd0,32'd0,  1,0,0,7'd0,32'd0,  0,0,0);
      step(1, 1,0,0,7'd0,32'd0,  1,0,0,7'd0,32'd0,  0,0,0);

      // A reads address 5, then B reads 7 so that B was granted last.
      step(0, 1,0,0,7'd5,32'd0,  0,0,0,7'd0,32'd0,  1,0,0);
      step(0, 0,0,0,7'd0,32'd0,  1,0,0,7'd7,32'd0,  0,1,0);

      // Both request reads for four cycles: A,B,A,B.
      step(0, 1,0,0,7'd10,32'd0, 1,0,0,7'd20,32'd0, 1,0,0);
      step(0, 1,0,0,7'd11,32'd0, 1,0,0,7'd20,32'd0, 0,1,0);
      step(0, 1,0,0,7'd11,32'd0, 1,0,0,7'd21,32'd0, 1,0,0);
      step(0, 1,0,0,7'd12,32'd0, 1,0,0,7'd21,32'd0, 0,1,0);

      // B writes address 3, A reads it back the next cycle.
      step(0, 0,0,0,7'd0,32'd0,  1,1,0,7'd3,32'h12345678, 0,1,0);
      step(0, 1,0,0,7'd3,32'd0,  0,0,0,7'd0,32'd0,  1,0,0);

      // A locks; B stalls until A's unlocking write, then is granted.
      step(0, 1,0,1,7'd5,32'd0,  0,0,0,7'd0,32'd0,  1,0,0);
      step(0, 0,0,0,7'd0,32'd0,  1,0,0,7'd30,32'd0, 0,0,0);
      step(0, 0,0,0,7'd0,32'd0,  1,0,0,7'd30,32'd0, 0,0,0);
      step(0, 1,1,0,7'd40,32'h55,1,0,0,7'd30,32'd0, 1,0,0);
      step(0, 0,0,0,7'd0,32'd0,  1,0,0,7'd30,32'd0, 0,1,0);

      // A locks and goes idle: 16 idle cycles, lock_err, then B granted.
      step(0, 1,0,1,7'd6,32'd0,  0,0,0,7'd0,32'd0,  1,0,0);
      for (int i = 0; i < 16; i++)
         step(0, 0,0,0,7'd0,32'd0, 1,0,0,7'd31,32'd0, 0,0,0);
      step(0, 0,0,0,7'd0,32'd0,  1,0,0,7'd31,32'd0, 0,0,1);
      step(0, 0,0,0,7'd0,32'd0,  1,0,0,7'd31,32'd0, 0,1,0);
      step(0, 0,0,0,7'd0,32'd0,  0,0,0,7'd0,32'd0,  0,0,0);

      // A locked read, then reset: return suppressed, lock dropped, A first.
      step(0, 1,0,1,7'd5,32'd0,  0,0,0,7'd0,32'd0,  1,0,0);
      step(1, 1,0,0,7'd5,32'd0,  1,0,0,7'd9,32'd0,  0,0,0);
      step(0, 1,0,0,7'd8,32'd0,  1,0,0,7'd9,32'd0,  1,0,0);
      step(0, 0,0,0,7'd0,32'd0,  1,0,0,7'd9,32'd0,  0,1,0);
      step(0, 0,0,0,7'd0,32'd0,  0,0,0,7'd0,32'd0,  0,0,0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
